// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// The result is computed when the op is accepted and committed to HI/LO after the op's latency.
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     count, count_next;
  logic              finish;
  logic              accept, is_move, is_div;
  logic [WIDTH-1:0]  res_hi, res_lo, res_hi_next, res_lo_next;
  logic              res_wr, res_wr_next;

  logic [2*WIDTH-1:0] a_sx, b_sx, prod_s, prod_u, acc;
  logic [WIDTH-1:0]   a_mag, b_mag, div_s, uq_s, ur_s, div_u;

  assign accept  = start && (state == IDLE);
  assign is_move = (op[2:1] == 2'b10);
  assign is_div  = (op[2:1] == 2'b01);
  assign busy    = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !is_move) begin
          state_next = RUN;
          count_next = is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
        end
      end
      RUN: begin
        if (count == '0) begin
          state_next = IDLE;
          finish     = 1'b1;
        end else begin
          count_next = count - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Signed division runs on magnitudes; most-negative / -1 falls out as quotient == A, remainder 0.
  always_comb begin
    a_sx   = {{WIDTH{A[WIDTH-1]}}, A};
    b_sx   = {{WIDTH{B[WIDTH-1]}}, B};
    prod_s = a_sx * b_sx;
    prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    acc    = {hi, lo};
    a_mag  = A[WIDTH-1] ? -A : A;
    b_mag  = B[WIDTH-1] ? -B : B;
    div_s  = (b_mag == '0) ? WIDTH'(1) : b_mag;
    uq_s   = a_mag / div_s;
    ur_s   = a_mag % div_s;
    div_u  = (B == '0) ? WIDTH'(1) : B;

    {res_hi_next, res_lo_next} = prod_s;
    res_wr_next = 1'b1;
    case (op)
      3'b001: {res_hi_next, res_lo_next} = prod_u;
      3'b010: begin
        res_lo_next = (A[WIDTH-1] ^ B[WIDTH-1]) ? -uq_s : uq_s;
        res_hi_next = A[WIDTH-1] ? -ur_s : ur_s;
        res_wr_next = (B != '0);
      end
      3'b011: begin
        res_lo_next = A / div_u;
        res_hi_next = A % div_u;
        res_wr_next = (B != '0);
      end
      3'b110: {res_hi_next, res_lo_next} = acc + prod_s;
      3'b111: {res_hi_next, res_lo_next} = acc - prod_s;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      res_hi <= '0;
      res_lo <= '0;
      res_wr <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        if (op == 3'b100) begin
          hi <= A;
        end else if (op == 3'b101) begin
          lo <= A;
        end else begin
          res_hi <= res_hi_next;
          res_lo <= res_lo_next;
          res_wr <= res_wr_next;
        end
      end
      if (finish && res_wr) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: expected HI/LO pushed at issue, popped and compared on done.
module tb_mdu_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = '0, B = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int vectors = 0, miscompares = 0;
  logic [63:0] scoreboard[$];
  logic [31:0] m_hi = '0, m_lo = '0;

  mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] cur);
    logic [63:0] r;
    longint sp;
    int sa, sbv;
    r = cur;
    sa = a;
    sbv = b;
    sp = longint'(sa) * longint'(sbv);
    case (o)
      3'd0: r = sp;
      3'd1: r = {32'b0, a} * {32'b0, b};
      3'd2: if (b != 0) begin
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'b0, a};
        else r = {32'(sa % sbv), 32'(sa / sbv)};
      end
      3'd3: if (b != 0) r = {a % b, a / b};
      3'd4: r = {a, cur[31:0]};
      3'd5: r = {cur[63:32], a};
      3'd6: r = cur + sp;
      default: r = cur - sp;
    endcase
    return r;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    e = model(o, a, b, {m_hi, m_lo});
    if (o != 3'd4 && o != 3'd5) scoreboard.push_back(e);
    {m_hi, m_lo} = e;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge after t0; returns busy cycles seen before done (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      if (busy) n++;
      else n += 50;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h required all zero", busy, done, hi, lo);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mult;
    int n;
    logic [63:0] e;
    for (int i = 0; i < 2; i++) begin
      issue(3'(i), 32'hFFFFFFFE, 32'd3);
      wait_done(n);
      e = scoreboard.pop_front();
      vectors++;
      if (n !== 5 || done !== 1'b1 || {hi, lo} !== e) begin
        miscompares++;
        $display("FAIL mult op%0d: lat=%0d done=%b hilo=%h required lat=5 done=1 hilo=%h", i, n, done, {hi, lo}, e);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL done_pulse: done=%b busy=%b required 0 0", done, busy);
      end
    end
  endtask

  task automatic test_div;
    int n;
    logic [63:0] e;
    logic [2:0]  ops[4] = '{3'd2, 3'd3, 3'd2, 3'd2};
    logic [31:0] as[4]  = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd5};
    logic [31:0] bs[4]  = '{32'd2, 32'd2, 32'hFFFFFFFF, 32'd0};
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        issue(3'd4, 32'h11, 32'd0);
        issue(3'd5, 32'h22, 32'd0);
        vectors++;
        if (hi !== 32'h11 || lo !== 32'h22 || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL mthi_mtlo: hi=%h lo=%h busy=%b required 11 22 0", hi, lo, busy);
        end
      end
      issue(ops[i], as[i], bs[i]);
      wait_done(n);
      e = scoreboard.pop_front();
      vectors++;
      if (n !== 10 || done !== 1'b1 || {hi, lo} !== e) begin
        miscompares++;
        $display("FAIL div case%0d: lat=%0d done=%b hilo=%h required lat=10 done=1 hilo=%h", i, n, done, {hi, lo}, e);
      end
    end
  endtask

  task automatic test_madd_msub;
    int n;
    logic [63:0] e;
    issue(3'd4, 32'h12345678, 32'd0);
    issue(3'd5, 32'd1, 32'd0);
    for (int i = 0; i < 2; i++) begin
      if (i == 0) issue(3'd6, 32'd2, 32'd3);
      else issue(3'd7, 32'd1, 32'd8);
      wait_done(n);
      e = scoreboard.pop_front();
      vectors++;
      if (n !== 5 || {hi, lo} !== e) begin
        miscompares++;
        $display("FAIL madd_msub step%0d: lat=%0d hilo=%h required lat=5 hilo=%h", i, n, {hi, lo}, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n, c;
    logic [63:0] e;
    issue(3'd2, 32'hFFFFFF9C, 32'd7);
    c = 1; n = 0;
    while (!done && c < 200) begin
      if (busy) n++;
      start = (c == 2 || c == 5);
      op = (c == 5) ? 3'd5 : 3'd0;
      A = 32'hDEADBEEF; B = 32'd3;
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    e = scoreboard.pop_front();
    vectors++;
    if (n !== 10 || done !== 1'b1 || {hi, lo} !== e) begin
      miscompares++;
      $display("FAIL ignored_start: lat=%0d done=%b hilo=%h required lat=10 done=1 hilo=%h", n, done, {hi, lo}, e);
    end
    start = 1'b1; op = 3'd1; A = 32'd3; B = 32'd4;
    e = model(3'd1, 32'd3, 32'd4, {m_hi, m_lo});
    scoreboard.push_back(e);
    {m_hi, m_lo} = e;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL back_to_back_accept: busy=%b required 1", busy);
    end
    wait_done(n);
    e = scoreboard.pop_front();
    vectors++;
    if (n !== 5 || {hi, lo} !== e) begin
      miscompares++;
      $display("FAIL back_to_back: lat=%0d hilo=%h required lat=5 hilo=%h", n, {hi, lo}, e);
    end
  endtask

  task automatic test_random;
    int n;
    logic [2:0]  o;
    logic [31:0] a, b;
    logic [63:0] e;
    for (int i = 0; i < 12; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom);
      issue(o, a, b);
      if (o == 3'd4 || o == 3'd5) begin
        vectors++;
        if ({hi, lo} !== {m_hi, m_lo} || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_move%0d: hilo=%h busy=%b required hilo=%h busy=0", i, {hi, lo}, busy, {m_hi, m_lo});
        end
      end else begin
        wait_done(n);
        e = scoreboard.pop_front();
        vectors++;
        if (n !== ((o[2:1] == 2'b01) ? 10 : 5) || {hi, lo} !== e) begin
          miscompares++;
          $display("FAIL rand_op%0d op=%0d a=%h b=%h: lat=%0d hilo=%h required hilo=%h", i, o, a, b, n, {hi, lo}, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    issue(3'd4, 32'h55, 32'd0);
    issue(3'd0, 32'd9, 32'd9);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b required 0 0 0 0", hi, lo, busy, done);
    end
    scoreboard.delete();
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0 || {hi, lo} !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_abort: activity=%b hilo=%h required 0 0", seen, {hi, lo});
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_madd_msub;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
